// File: rtl/trig_arb_pkg.sv
// Shared types and default sizing for the timestamp readout arbiter.
// Holds the FSM state encoding used by readout_arbiter.
package trig_arb_pkg;

    localparam int ARB_NUM_CH     = 4;
    localparam int ARB_WORD_WIDTH = 24;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/readout_arbiter_rr_pick.sv
// Round-robin picker: first requesting channel strictly after 'last', wrapping.
// Latency: combinational. Backpressure: none, pure function of req/last.
module rr_pick #(
    parameter int NUM_CH   = 4,
    parameter int ID_WIDTH = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                any,
    output logic [ID_WIDTH-1:0] grant
);

    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        // Search order last+1 .. last+NUM_CH, so 'last' itself is checked last.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ID_WIDTH'((int'(last) + k) % NUM_CH);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/readout_arbiter.sv
// Purpose: round-robin arbiter feeding one held timestamp word to a shared shifter;
// latency: ch_valid seen in IDLE -> out_valid next cycle; backpressure: word held until out_fetched.
// Option ARB_CH_TAG_EN prepends the granted channel id to out_word.
module readout_arbiter
    import trig_arb_pkg::*;
#(
    parameter int NUM_CH     = ARB_NUM_CH,
    parameter int WORD_WIDTH = ARB_WORD_WIDTH,
    parameter int ID_WIDTH   = $clog2(NUM_CH)
`ifdef ARB_CH_TAG_EN
    , localparam int OUT_W   = ID_WIDTH + WORD_WIDTH
`else
    , localparam int OUT_W   = WORD_WIDTH
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*WORD_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_pop,
    output logic                         out_valid,
    output logic [OUT_W-1:0]             out_word,
    input  logic                         out_fetched
);

    arb_state_t            state;
    logic [WORD_WIDTH-1:0] hold_word;
    logic [ID_WIDTH-1:0]   last_grant;
    logic                  pick_any;
    logic [ID_WIDTH-1:0]   pick_grant;
    logic [WORD_WIDTH-1:0] ch_word [NUM_CH];

`ifdef ARB_CH_TAG_EN
    logic [ID_WIDTH-1:0]   hold_id;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_word[i] = ch_data[i*WORD_WIDTH +: WORD_WIDTH];
    end

    rr_pick #(
        .NUM_CH   (NUM_CH),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req   (ch_valid),
        .last  (last_grant),
        .any   (pick_any),
        .grant (pick_grant)
    );

    // Arbitration only happens from IDLE, which always lasts at least one cycle,
    // so a just-popped queue has updated its ch_valid before it competes again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            ch_pop     <= '0;
            hold_word  <= '0;
            last_grant <= ID_WIDTH'(NUM_CH - 1);
`ifdef ARB_CH_TAG_EN
            hold_id    <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    ch_pop <= '0;
                    if (pick_any) begin
                        hold_word  <= ch_word[pick_grant];
                        last_grant <= pick_grant;
                        ch_pop     <= NUM_CH'(1) << pick_grant;
                        state      <= ARB_PRESENT;
`ifdef ARB_CH_TAG_EN
                        hold_id    <= pick_grant;
`endif
                    end
                end
                ARB_PRESENT: begin
                    ch_pop <= '0;
                    if (out_fetched) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    ch_pop <= '0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == ARB_PRESENT);

`ifdef ARB_CH_TAG_EN
    assign out_word = {hold_id, hold_word};
`else
    assign out_word = hold_word;
`endif

endmodule

// File: tb/tb_readout_arbiter.sv
// Randomized and directed bench for readout_arbiter against a behavioural model.
module tb_readout_arbiter;

    localparam int NUM_CH = 4;
    localparam int WW     = 24;
    localparam int IDW    = 2;
`ifdef ARB_CH_TAG_EN
    localparam int OUT_W  = IDW + WW;
`else
    localparam int OUT_W  = WW;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH*WW-1:0]   ch_data;
    logic [NUM_CH-1:0]      ch_pop;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_word;
    logic                   out_fetched;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural reference state
    bit                m_present;
    int                m_last;
    logic [WW-1:0]     m_word;
    int                m_id;
    logic [NUM_CH-1:0] m_pop;

    readout_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_pop      (ch_pop),
        .out_valid   (out_valid),
        .out_word    (out_word),
        .out_fetched (out_fetched)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] word_of(input int ch);
        return ch_data[ch*WW +: WW];
    endfunction

    task automatic set_word(input int ch, input logic [WW-1:0] w);
        ch_data[ch*WW +: WW] = w;
    endtask

    // Next channel after the previous grant, in circular order, that is requesting.
    function automatic int model_pick();
        for (int k = 1; k <= NUM_CH; k++) begin
            if (ch_valid[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        if (!rst_n) begin
            m_present = 0;
            m_pop     = '0;
            m_word    = '0;
            m_id      = 0;
            m_last    = NUM_CH - 1;
        end else if (!m_present) begin
            m_pop = '0;
            g = model_pick();
            if (g >= 0) begin
                m_word    = word_of(g);
                m_id      = g;
                m_last    = g;
                m_pop     = '0;
                m_pop[g]  = 1'b1;
                m_present = 1;
            end
        end else begin
            m_pop = '0;
            if (out_fetched) m_present = 0;
        end
    endtask

    function automatic logic [OUT_W-1:0] model_out();
`ifdef ARB_CH_TAG_EN
        return {IDW'(m_id), m_word};
`else
        return m_word;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("out_valid", 64'(out_valid), 64'(m_present));
        check("out_word", 64'(out_word), 64'(model_out()));
        check("ch_pop", 64'(ch_pop), 64'(m_pop));
    endtask

    function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v == (NUM_CH'(1) << i)) return i;
        return -1;
    endfunction

    int grants[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int pops;
    int waited;
    logic [WW-1:0] held;

    initial begin
        rst_n = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        out_fetched = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pop", 64'(ch_pop), 64'd0);

        // Single request on channel 0
        rst_n = 1'b1;
        ch_valid = 4'b0001;
        set_word(0, 24'h00ABCD);
        tick();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_data", 64'(out_word[WW-1:0]), 64'h00ABCD);
        check("first_pop", 64'(ch_pop), 64'b0001);
`ifdef ARB_CH_TAG_EN
        check("first_tag", 64'(out_word[OUT_W-1:WW]), 64'd0);
`endif
        ch_valid = '0;
        tick();
        check("first_pop_clear", 64'(ch_pop), 64'd0);
        out_fetched = 1'b1;
        tick();
        out_fetched = 1'b0;
        tick();

        // All channels valid: round-robin order. Last grant was 0, so reset pointer first.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ch_valid = 4'b1111;
        for (int c = 0; c < NUM_CH; c++) set_word(c, WW'(24'h100000 + c));
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!out_valid && waited < 10);
            if (!out_valid) check("rr_timeout", 64'd1, 64'd0);
            grants.push_back(onehot_idx(ch_pop));
            check("rr_data", 64'(out_word[WW-1:0]), 64'(24'h100000 + exp_order[n]));
            out_fetched = 1'b1;
            tick();
            out_fetched = 1'b0;
        end
        for (int n = 0; n < 5; n++) check("rr_order", 64'(grants[n]), 64'(exp_order[n]));

        // Channel 2 held 20 cycles while its data changes
        ch_valid = '0;
        tick();
        tick();
        ch_valid = 4'b0100;
        set_word(2, 24'h222222);
        held = 24'h222222;
        pops = 0;
        tick();
        if (ch_pop != 0) pops++;
        for (int n = 0; n < 19; n++) begin
            set_word(2, WW'($urandom));
            tick();
            if (ch_pop != 0) pops++;
            check("hold_word", 64'(out_word[WW-1:0]), 64'(held));
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        check("hold_pops", 64'(pops), 64'd1);
        ch_valid = '0;
        out_fetched = 1'b1;
        tick();
        out_fetched = 1'b0;
        tick();

        // out_fetched while idle has no effect
        for (int n = 0; n < 3; n++) begin
            out_fetched = 1'b1;
            tick();
            check("idle_fetch_valid", 64'(out_valid), 64'd0);
            check("idle_fetch_pop", 64'(ch_pop), 64'd0);
        end
        out_fetched = 1'b0;

        // Reset while channel 1 is presented
        ch_valid = 4'b0010;
        set_word(1, 24'h111111);
        tick();
        check("pre_rst_pop", 64'(ch_pop), 64'b0010);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_pop", 64'(ch_pop), 64'd0);
        rst_n = 1'b1;
        ch_valid = 4'b0110;
        tick();
        check("post_rst_grant", 64'(ch_pop), 64'b0010);
        ch_valid = '0;
        out_fetched = 1'b1;
        tick();
        out_fetched = 1'b0;

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            ch_valid    = NUM_CH'($urandom);
            out_fetched = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < NUM_CH; c++) set_word(c, WW'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
